// File: rtl/moving_avg_mc.sv
// rtl/moving_avg_mc.sv - multi-channel moving-average filter with valid/ready handshake
// Per-channel shift window plus full-width running sum; registered sum or average output.
module moving_avg_mc #(
  parameter int CHANNELS   = 3,
  parameter int SAMPLE_W   = 2,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0]               in_data,
  input  logic                                       mode,
  input  logic                                       clear,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [CHANNELS*(SAMPLE_W+LOG2_DEPTH)-1:0]  out_data,
  output logic                                       out_full,
  output logic [LOG2_DEPTH:0]                        fill_count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int OUT_W = SAMPLE_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] ONE_C   = (LOG2_DEPTH+1)'(1);

  // Index 0 is the newest sample, DEPTH-1 the oldest.
  logic [SAMPLE_W-1:0]       win_q [CHANNELS][DEPTH];
  logic [SAMPLE_W-1:0]       win_d [CHANNELS][DEPTH];
  logic [OUT_W-1:0]          sum_q [CHANNELS];
  logic [OUT_W-1:0]          sum_d [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_full_q, out_full_d;
  logic [LOG2_DEPTH:0]       fill_q, fill_d;
  logic [LOG2_DEPTH:0]       fill_next;
  logic                      accept;

  always_comb begin
    win_d       = win_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_full_d  = out_full_q;
    fill_d      = fill_q;
    in_ready    = ~clear & (~out_valid_q | out_ready);
    accept      = in_valid & in_ready;
    fill_next   = (fill_q == DEPTH_C) ? fill_q : fill_q + ONE_C;

    if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < DEPTH; i++) win_d[c][i] = '0;
        sum_d[c] = '0;
      end
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_full_d  = 1'b0;
      fill_d      = '0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        win_d[c][0] = in_data[c*SAMPLE_W +: SAMPLE_W];
        for (int i = 1; i < DEPTH; i++) win_d[c][i] = win_q[c][i-1];
        // Zero pre-fill makes add-new/subtract-oldest exact from the first accept.
        sum_d[c] = sum_q[c] + OUT_W'(in_data[c*SAMPLE_W +: SAMPLE_W])
                            - OUT_W'(win_q[c][DEPTH-1]);
        out_data_d[c*OUT_W +: OUT_W] = mode ? sum_d[c] : (sum_d[c] >> LOG2_DEPTH);
      end
      fill_d      = fill_next;
      out_full_d  = (fill_next == DEPTH_C);
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < DEPTH; i++) win_q[c][i] <= '0;
        sum_q[c] <= '0;
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_full_q  <= 1'b0;
      fill_q      <= '0;
    end else begin
      win_q       <= win_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_full_q  <= out_full_d;
      fill_q      <= fill_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_full   = out_full_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_moving_avg_mc.sv
// tb/tb_moving_avg_mc.sv - self-checking bench for moving_avg_mc
// Queue-based reference model checked every cycle, plus literal scenario checks.
module tb_moving_avg_mc;

  logic        clk, rst;
  logic        in_valid, in_ready, mode, clear, out_valid, out_ready, out_full;
  logic [5:0]  in_data;
  logic [11:0] out_data;
  logic [2:0]  fill_count;

  logic        w_valid, w_ready, w_mode, w_clear, w_out_valid, w_out_ready, w_out_full;
  logic [7:0]  w_data;
  logic [10:0] w_out_data;
  logic [3:0]  w_fill;

  int n_checks = 0;
  int n_fail   = 0;

  moving_avg_mc dut (
    .clk(clk), .rst_n(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_full(out_full), .fill_count(fill_count)
  );

  moving_avg_mc #(.CHANNELS(1), .SAMPLE_W(8), .LOG2_DEPTH(3)) dut_w (
    .clk(clk), .rst_n(rst), .in_valid(w_valid), .in_ready(w_ready), .in_data(w_data),
    .mode(w_mode), .clear(w_clear), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_full(w_out_full), .fill_count(w_fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: last DEPTH samples per channel kept in a queue.
  int m_hist [3][$];
  int m_data [3];
  bit m_ov, m_full;
  int m_fill;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_hist[c].delete();
      m_data[c] = 0;
    end
    m_ov = 0; m_full = 0; m_fill = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      model_reset();
    end else if (in_valid && (!m_ov || out_ready)) begin
      for (int c = 0; c < 3; c++) begin
        int s;
        m_hist[c].push_back(int'(in_data[c*2 +: 2]));
        if (m_hist[c].size() > 4) void'(m_hist[c].pop_front());
        s = 0;
        foreach (m_hist[c][k]) s += m_hist[c][k];
        m_data[c] = mode ? s : s / 4;
      end
      m_fill = (m_fill < 4) ? m_fill + 1 : 4;
      m_full = (m_fill == 4);
      m_ov   = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("out_valid", out_valid, m_ov);
      chk("fill_count", fill_count, m_fill);
      chk("out_full", out_full, m_full);
      chk("in_ready", in_ready, !clear && (!m_ov || out_ready));
      if (m_ov)
        for (int c = 0; c < 3; c++) chk($sformatf("out_data_ch%0d", c), out_data[c*4 +: 4], m_data[c]);
    end
  end

  task automatic push(input int d0, input int d1, input int d2, input bit md);
    logic [1:0] a, b, e;
    a = d0[1:0]; b = d1[1:0]; e = d2[1:0];
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {e, b, a};
    mode     = md;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  int exp_s1 [5] = '{3, 6, 9, 12, 12};
  int exp_f1 [5] = '{0, 0, 0, 1, 1};
  int exp_s2 [5] = '{0, 1, 2, 3, 3};
  int in_s3  [5] = '{1, 2, 3, 0, 0};
  int exp_s3 [5] = '{1, 3, 6, 6, 5};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
    w_valid = 1'b0; w_data = '0; w_mode = 1'b1; w_clear = 1'b0; w_out_ready = 1'b1;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_fill", fill_count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      push(3, 0, 0, 1'b1);
      chk("s1_sum_ch0", out_data[3:0], exp_s1[i]);
      chk("s1_full", out_full, exp_f1[i]);
    end
    chk("s1_fill_end", fill_count, 4);

    do_clear();
    for (int i = 0; i < 5; i++) begin
      push(3, 0, 0, 1'b0);
      chk("s2_avg_ch0", out_data[3:0], exp_s2[i]);
    end

    do_clear();
    for (int i = 0; i < 5; i++) begin
      push(0, in_s3[i], 0, 1'b1);
      chk("s3_sum_ch1", out_data[7:4], exp_s3[i]);
      chk("s3_ch2_zero", out_data[11:8], 0);
    end

    do_clear();
    push(2, 0, 0, 1'b1);
    chk("s4_first", out_data[3:0], 2);
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = 6'b000001;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("s4_stall_ready", in_ready, 0);
      chk("s4_stall_hold", out_data[3:0], 2);
      chk("s4_stall_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("s4_ready_on_consume", in_ready, 1);
    @(posedge clk);
    #1;
    chk("s4_reload_valid", out_valid, 1);
    chk("s4_reload_sum", out_data[3:0], 3);
    chk("s4_fill", fill_count, 2);
    @(negedge clk);
    in_valid = 1'b0;

    push(1, 1, 1, 1'b1);
    push(3, 2, 1, 1'b1);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 6'b111111;
    @(posedge clk);
    #1;
    chk("s5_fill_zero", fill_count, 0);
    chk("s5_valid_zero", out_valid, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    push(2, 0, 0, 1'b1);
    chk("s5_restart_sum", out_data[3:0], 2);
    chk("s5_restart_fill", fill_count, 1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data   = 6'($urandom);
      mode      = 1'($urandom);
      clear     = ($urandom % 25) == 0;
    end
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b1;

    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_data  = 8'd255;
      @(posedge clk);
      #1;
      chk("s6_wide_sum", w_out_data, 255 * ((k < 8) ? k : 8));
      chk("s6_wide_full", w_out_full, k >= 8);
    end
    @(negedge clk);
    w_valid = 1'b0;

    push(3, 3, 3, 1'b1);
    push(3, 3, 3, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_valid", out_valid, 0);
    chk("s6_async_data", out_data, 0);
    chk("s6_async_fill", fill_count, 0);
    chk("s6_async_wide", w_out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    push(1, 0, 0, 1'b1);
    chk("s6_post_reset_sum", out_data[3:0], 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moving_avg_mc.md
# moving_avg_mc

Parametrised multi-channel moving-average filter. It is the successor to the fixed 3-channel, 2-bit, depth-4 averager and sits between the sample-input pins and the output pins. It adds configurable channel count, sample width and window depth, plus a full-width (non-wrapping) running sum, a sum/average mode select, a valid/ready handshake on both sides, a synchronous flush, and a window-full indication.

## Interface
- CHANNELS, default 3: number of independent channels.
- SAMPLE_W, default 2: bits per sample, unsigned.
- LOG2_DEPTH, default 2: the window depth DEPTH = 2^LOG2_DEPTH. Legal range is 1..6.
- Derived value OUT_W = SAMPLE_W + LOG2_DEPTH: per-channel output width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset. The name is kept for pin compatibility; the polarity is high.
- in_valid  in  1  a sample vector is present on in_data.
- in_ready  out  1  the block can accept a sample this cycle.
- in_data  in  CHANNELS*SAMPLE_W  channel c is in bits [c*SAMPLE_W +: SAMPLE_W].
- mode  in  1  0 = average (sum >> LOG2_DEPTH), 1 = raw window sum. Sampled at accept.
- clear  in  1  synchronous flush of the window, sums, fill count and output register.
- out_valid  out  1  out_data holds a result that has not yet been consumed.
- out_ready  in  1  the downstream block consumes the result when out_valid is also 1.
- out_data  out  CHANNELS*OUT_W  channel c is in bits [c*OUT_W +: OUT_W].
- out_full  out  1  the window was completely filled when this result was produced.
- fill_count  out  LOG2_DEPTH+1  number of samples in the window. Saturates at DEPTH.

## Operation
- **Window storage:** per channel, a DEPTH-entry shift window and a running sum of width OUT_W. Before any sample arrives, the window is pre-filled with zeros.
- **Accept condition:** accept = in_valid & in_ready.
- **in_ready:** in_ready = ~clear & (~out_valid | out_ready). It is combinational.
- **On accept, for each channel:**
  - The window shifts by one. The new sample enters at the newest slot and the oldest sample is dropped.
  - sum_next = sum + new - oldest, computed at OUT_W bits. It cannot overflow, because the maximum is DEPTH*(2^SAMPLE_W - 1).
- **Output register load on accept:**
  - out_data[c] = sum_next if mode = 1. Otherwise it is {LOG2_DEPTH'b0, sum_next[OUT_W-1:LOG2_DEPTH]}, i.e. truncating division by DEPTH, including while the window is partially filled.
  - out_full = (fill_count_next == DEPTH).
  - out_valid is set to 1.
- **fill_count:** increments on each accept and saturates at DEPTH.
- **Output handshake:** if out_valid & out_ready and there is no accept in the same cycle, out_valid clears. If both occur in the same cycle, the register reloads and out_valid stays 1 (full throughput, one result per cycle).
- **Stall:** while out_valid = 1 and out_ready = 0, out_data and out_full hold stable and no sample is accepted.
- **clear = 1:**
  - In the next cycle, all windows, sums, fill_count, out_valid, out_data and out_full are 0.
  - in_ready is 0 during clear, so a sample presented in the same cycle is not accepted.
  - clear has priority over accept and over consume.
- **mode changes:** a change to mode affects only results produced by later accepts. Sums are mode-independent.
- **No output gating by enable:** there is no ena/output gating. Downstream logic qualifies outputs with out_valid.

## Timing
- **Reset values:** while rst_n = 1, and asynchronously on its assertion, out_valid = 0, out_data = 0, out_full = 0 and fill_count = 0. All windows and sums are 0. in_ready = 1 once clear = 0, because out_valid = 0.
- **Reset mid-operation:** asserting rst_n at any point discards every window and any pending output immediately, without waiting for a clock edge.
- **Latency:** a sample accepted at edge N appears on out_data with out_valid = 1 after edge N, i.e. one cycle.
- **Throughput:** one sample per cycle when out_ready = 1.
- **Window boundary:**
  - out_full first goes to 1 on the result of the DEPTH-th accept after reset or clear.
  - out_full stays 1 afterwards until reset or clear.
- **No combinational paths** from in_data or mode to any output. in_ready depends only on clear, out_valid and out_ready.

## Test plan
All scenarios use the default parameters (3 channels, 2-bit samples, depth 4, so OUT_W = 4) unless stated otherwise.
1. **Sum build-up:** reset, mode = 1, out_ready = 1, channel 0 held at 3 for 5 accepts.
   - Channel 0 outputs must be 3, 6, 9, 12, 12.
   - out_full must be 0, 0, 0, 1, 1.
   - fill_count must end at 4.
2. **Average mode:** same stimulus with mode = 0. Channel 0 outputs must be 0, 1, 2, 3, 3.
3. **Sliding window:** mode = 1, channel 1 fed 1, 2, 3, 0, 0.
   - Channel 1 outputs must be 1, 3, 6, 6, 5.
   - Channel 2 must stay 0 when fed zeros (checks channel independence).
4. **Backpressure:**
   - Drop out_ready after the first result. in_ready must go to 0, out_data must hold, and no sample is lost.
   - Raise out_ready with in_valid held high. The next sample must be accepted in the same cycle as the consume, and out_valid must stay 1.
5. **Flush:** mid-stream, assert clear for 1 cycle with in_valid = 1.
   - That sample must not be accepted.
   - The next cycle must show fill_count = 0 and out_valid = 0.
   - Feeding 2 then gives a sum of 2, not a continuation of the old sum.
6. **Async reset and wide config:** assert rst_n between clock edges mid-stream. Outputs must zero before the next edge. Rerun scenario 1 with SAMPLE_W = 8 and LOG2_DEPTH = 3, channel 0 held at 255: the sum must reach 2040 with no wrap.
